// File: rtl/register_file_sb.sv
// Register file with two write ports, N_RD combinational reads and a per-register pending-write scoreboard.
// Latency: reads 0 cycles, writes visible next cycle (same cycle with RF_BYPASS_EN); collision/underflow registered.
// Backpressure: none on writes; reservations are refused via o_rsv_ready when a register's count is at max.
module register_file_sb #(
    parameter int REG_WIDTH  = 34,
    parameter int ADDR_WIDTH = 5,
    parameter int N_RD       = 3,
    parameter int PEND_W     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_RD*ADDR_WIDTH-1:0]   i_rd_addr,
    output logic [N_RD*REG_WIDTH-1:0]    o_rd_data,
    output logic [N_RD-1:0]              o_rd_busy,
    input  logic                         i_wa_en,
    input  logic [ADDR_WIDTH-1:0]        i_wa_addr,
    input  logic [REG_WIDTH-1:0]         i_wa_data,
    input  logic                         i_wm_en,
    input  logic [ADDR_WIDTH-1:0]        i_wm_addr,
    input  logic [REG_WIDTH-1:0]         i_wm_data,
    input  logic                         i_rsv_en,
    input  logic [ADDR_WIDTH-1:0]        i_rsv_addr,
    output logic                         o_rsv_ready,
    output logic                         o_collision,
    output logic                         o_underflow_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NW    = PEND_W + 2;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [REG_WIDTH-1:0] mem     [DEPTH];
    logic [PEND_W-1:0]    cnt     [DEPTH];
    logic [PEND_W-1:0]    cnt_nxt [DEPTH];
    logic                 uf_any;
    logic                 wa_hit;
    logic                 wm_hit;
    logic                 rsv_hit;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wa_hit      = i_wa_en && addr_ok(i_wa_addr);
    assign wm_hit      = i_wm_en && addr_ok(i_wm_addr);
    // Registered count only: no combinational path from the write ports.
    assign o_rsv_ready = addr_ok(i_rsv_addr) && (cnt[i_rsv_addr] != CNT_MAX);
    assign rsv_hit     = i_rsv_en && o_rsv_ready;

    always_comb begin
        uf_any = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            logic [NW-1:0] net;
            net = NW'(cnt[r])
                + NW'(rsv_hit && (i_rsv_addr == ADDR_WIDTH'(r)))
                - NW'(wa_hit && (i_wa_addr == ADDR_WIDTH'(r)))
                - NW'(wm_hit && (i_wm_addr == ADDR_WIDTH'(r)));
            cnt_nxt[r] = net[NW-1] ? '0 : net[PEND_W-1:0];
            if (net[NW-1]) begin
                uf_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
                cnt[r] <= '0;
            end
            o_collision     <= 1'b0;
            o_underflow_err <= 1'b0;
        end else begin
            if (wa_hit) begin
                mem[i_wa_addr] <= i_wa_data;
            end
            // M is written last so it wins an address collision with A.
            if (wm_hit) begin
                mem[i_wm_addr] <= i_wm_data;
            end
            for (int r = 0; r < DEPTH; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            o_collision <= wa_hit && wm_hit && (i_wa_addr == i_wm_addr);
            if (uf_any) begin
                o_underflow_err <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            o_rd_data[k*REG_WIDTH +: REG_WIDTH] = mem[ra];
            o_rd_busy[k] = 1'b0;
`ifdef RF_BYPASS_EN
            if (wm_hit && (i_wm_addr == ra)) begin
                o_rd_data[k*REG_WIDTH +: REG_WIDTH] = i_wm_data;
            end else if (wa_hit && (i_wa_addr == ra)) begin
                o_rd_data[k*REG_WIDTH +: REG_WIDTH] = i_wa_data;
            end
            o_rd_busy[k] = NW'(cnt[ra]) > (NW'(wa_hit && (i_wa_addr == ra))
                                        + NW'(wm_hit && (i_wm_addr == ra)));
`else
            o_rd_busy[k] = (cnt[ra] != '0);
`endif
            if (!addr_ok(ra)) begin
                o_rd_data[k*REG_WIDTH +: REG_WIDTH] = '0;
                o_rd_busy[k] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Randomised bench for register_file_sb against a behavioural array model, plus directed literal checks.
module tb_register_file_sb;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] rd_addr;
    logic [101:0] rd_data;
    logic [2:0]  rd_busy;
    logic        wa_en, wm_en, rsv_en;
    logic [4:0]  wa_addr, wm_addr, rsv_addr;
    logic [33:0] wa_data, wm_data;
    logic        rsv_ready, collision, underflow_err;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [33:0] m_mem [32];
    int          m_cnt [32];
    bit          m_col = 1'b0;
    bit          m_uf  = 1'b0;

    register_file_sb dut (
        .clk(clk), .rst(rst),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_busy(rd_busy),
        .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
        .i_wm_en(wm_en), .i_wm_addr(wm_addr), .i_wm_data(wm_data),
        .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_rsv_ready(rsv_ready),
        .o_collision(collision), .o_underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic bit m_eff(input logic en, input logic [4:0] a);
        return en && (a != 5'd0);
    endfunction

    // Reference: architectural state only, updated once per clock.
    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r] = '0;
                m_cnt[r] = 0;
            end
            m_col = 1'b0;
            m_uf  = 1'b0;
        end else begin
            bit ea, em, er;
            ea = m_eff(wa_en, wa_addr);
            em = m_eff(wm_en, wm_addr);
            er = rsv_en && (rsv_addr != 5'd0) && (m_cnt[rsv_addr] < 3);
            for (int r = 0; r < 32; r++) begin
                int n;
                n = m_cnt[r] + int'(er && rsv_addr == r) - int'(ea && wa_addr == r)
                    - int'(em && wm_addr == r);
                if (n < 0) begin
                    n = 0;
                    m_uf = 1'b1;
                end
                m_cnt[r] = n;
            end
            if (ea) m_mem[wa_addr] = wa_data;
            if (em) m_mem[wm_addr] = wm_data;
            m_col = ea && em && (wa_addr == wm_addr);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                logic [4:0]  a;
                logic [33:0] ed;
                int          rel;
                bit          eb;
                a   = rd_addr[k*5 +: 5];
                ed  = m_mem[a];
                rel = int'(m_eff(wa_en, wa_addr) && wa_addr == a)
                    + int'(m_eff(wm_en, wm_addr) && wm_addr == a);
                eb  = m_cnt[a] > 0;
                if (BYP) begin
                    if (m_eff(wm_en, wm_addr) && wm_addr == a) ed = wm_data;
                    else if (m_eff(wa_en, wa_addr) && wa_addr == a) ed = wa_data;
                    eb = (m_cnt[a] - rel) > 0;
                end
                if (a == 5'd0) begin
                    ed = '0;
                    eb = 1'b0;
                end
                chk($sformatf("rd_data%0d@%0d", k, a), 64'(rd_data[k*34 +: 34]), 64'(ed));
                chk($sformatf("rd_busy%0d@%0d", k, a), 64'(rd_busy[k]), 64'(eb));
            end
            chk("rsv_ready", 64'(rsv_ready), 64'((rsv_addr != 5'd0) && (m_cnt[rsv_addr] < 3)));
            chk("collision", 64'(collision), 64'(m_col));
            chk("underflow", 64'(underflow_err), 64'(m_uf));
        end
    end

    task automatic idle();
        wa_en = 0; wm_en = 0; rsv_en = 0;
        wa_addr = 0; wm_addr = 0; rsv_addr = 0;
        wa_data = 0; wm_data = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] t64;
        idle();
        rst = 1'b1;
        rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;
        rd_addr = {5'd31, 5'd5, 5'd1};
        look();
        for (int k = 0; k < 3; k++) begin
            chk("reset_data", 64'(rd_data[k*34 +: 34]), 64'd0);
            chk("reset_busy", 64'(rd_busy[k]), 64'd0);
        end
        chk("reset_uf", 64'(underflow_err), 64'd0);

        nxt(); rsv_en = 1; rsv_addr = 3;
        nxt(); wa_en = 1; wa_addr = 3; wa_data = 34'h0DEADBEEF; rd_addr = {5'd0, 5'd0, 5'd3};
        look();
        chk("wr_same_cycle", 64'(rd_data[33:0]), BYP ? 64'h0DEADBEEF : 64'd0);
        nxt();
        look();
        chk("wr_next_cycle", 64'(rd_data[33:0]), 64'h0DEADBEEF);
        chk("wr_busy_clear", 64'(rd_busy[0]), 64'd0);

        nxt(); rsv_en = 1; rsv_addr = 7;
        nxt(); rsv_en = 1; rsv_addr = 7;
        nxt(); wa_en = 1; wa_addr = 7; wa_data = 34'h1; wm_en = 1; wm_addr = 7; wm_data = 34'h2;
        rd_addr = {5'd0, 5'd0, 5'd7};
        nxt();
        look();
        chk("coll_data", 64'(rd_data[33:0]), 64'h2);
        chk("coll_pulse", 64'(collision), 64'd1);
        nxt();
        look();
        chk("coll_drop", 64'(collision), 64'd0);

        rd_addr = {5'd0, 5'd0, 5'd4};
        repeat (3) begin
            nxt(); rsv_en = 1; rsv_addr = 4;
        end
        nxt(); rsv_en = 1; rsv_addr = 4;
        look();
        chk("full_busy", 64'(rd_busy[0]), 64'd1);
        chk("full_not_ready", 64'(rsv_ready), 64'd0);
        nxt(); wa_en = 1; wa_addr = 4;
        nxt(); wa_en = 1; wa_addr = 4;
        nxt(); wa_en = 1; wa_addr = 4;
        look();
        chk("third_rel_busy", 64'(rd_busy[0]), BYP ? 64'd0 : 64'd1);
        nxt(); rsv_addr = 4;
        look();
        chk("drained_busy", 64'(rd_busy[0]), 64'd0);
        chk("drained_ready", 64'(rsv_ready), 64'd1);
        chk("no_uf_yet", 64'(underflow_err), 64'd0);

        nxt(); wa_en = 1; wa_addr = 9; rd_addr = {5'd0, 5'd0, 5'd9};
        nxt();
        look();
        chk("uf_set", 64'(underflow_err), 64'd1);
        chk("uf_busy", 64'(rd_busy[0]), 64'd0);
        repeat (3) nxt();
        look();
        chk("uf_sticky", 64'(underflow_err), 64'd1);

        nxt(); wa_en = 1; wa_addr = 0; wa_data = 34'h3FF; rsv_en = 1; rsv_addr = 0;
        rd_addr = '0;
        look();
        chk("z_data", 64'(rd_data[33:0]), 64'd0);
        chk("z_busy", 64'(rd_busy[0]), 64'd0);
        chk("z_ready", 64'(rsv_ready), 64'd0);
        nxt();
        look();
        chk("z_data_next", 64'(rd_data[33:0]), 64'd0);
        nxt(); rsv_en = 1; rsv_addr = 10;
        nxt(); rsv_en = 1; rsv_addr = 11;
        nxt(); rsv_en = 1; rsv_addr = 12; rst = 1'b1;
        nxt(); rst = 1'b0; rd_addr = {5'd12, 5'd11, 5'd10};
        look();
        chk("rst_busy", 64'(rd_busy), 64'd0);
        chk("rst_uf", 64'(underflow_err), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            nxt();
            rst = ($urandom_range(99, 0) == 0);
            for (int k = 0; k < 3; k++) begin
                rd_addr[k*5 +: 5] = ($urandom_range(3, 0) == 0) ? 5'($urandom) : 5'($urandom_range(7, 0));
            end
            wa_en = ($urandom_range(2, 0) == 0);
            wm_en = ($urandom_range(3, 0) == 0);
            rsv_en = $urandom_range(1, 0) == 1;
            wa_addr = 5'($urandom_range(7, 0));
            wm_addr = 5'($urandom_range(7, 0));
            rsv_addr = 5'($urandom_range(7, 0));
            t64 = {$urandom, $urandom};
            wa_data = t64[33:0];
            t64 = {$urandom, $urandom};
            wm_data = t64[33:0];
        end
        nxt();
        look();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
